alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_if.sv | 10 +
 rtl/alu_shifter.sv | 21 ++
 rtl/alu.sv | 66 ++++++
 tb/tb_alu.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, width default and small types for the ALU slice.
package alu_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [5:0] OP_AND = 6'b000000;
   localparam logic [5:0] OP_OR  = 6'b000001;
   localparam logic [5:0] OP_XOR = 6'b000010;
   localparam logic [5:0] OP_SLL = 6'b000110;
   localparam logic [5:0] OP_SRA = 6'b000100;
   localparam logic [5:0] OP_SRL = 6'b000101;
   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b111000;
   localparam logic [5:0] OP_SEQ = 6'b110000;
   localparam logic [5:0] OP_SNE = 6'b110001;
   localparam logic [5:0] OP_SLT = 6'b110010;
   localparam logic [5:0] OP_SGT = 6'b110011;
   localparam logic [5:0] OP_SLE = 6'b110100;
   localparam logic [5:0] OP_SGE = 6'b110110;

   typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shift_mode_e;

   // Flags taken from the shared subtractor; every set-op is decoded from these.
   typedef struct packed {
      logic z;
      logic n;
      logic v;
   } cmp_flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the ALU and whatever feeds it.
interface alu_if import alu_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             sel0, sel1, sel2, sel3, sel4, sel5;
   logic [WIDTH-1:0] out;

   modport master (output in1, in2, sel0, sel1, sel2, sel3, sel4, sel5, input out);
   modport slave  (input in1, in2, sel0, sel1, sel2, sel3, sel4, sel5, output out);
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: logical left, logical right, arithmetic right.
module alu_shifter import alu_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] data,
   input  logic [4:0]       shamt,
   input  shift_mode_e      mode,
   output logic [WIDTH-1:0] res
);

   always_comb begin
      res = '0;
      case (mode)
         SH_SLL:  res = data << shamt;
         SH_SRL:  res = data >> shamt;
         SH_SRA:  res = WIDTH'($signed(data) >>> shamt);
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Single-cycle ALU: combinational result path into one output register.
module alu import alu_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic  clk,
   input  logic  rst,
   alu_if.slave  bus
);

   logic [5:0]       op;
   logic [WIDTH-1:0] sum, diff, sh_res, res, out_q;
   shift_mode_e      sh_mode;
   cmp_flags_t       fl;
   logic             lt;

   assign op = {bus.sel5, bus.sel4, bus.sel3, bus.sel2, bus.sel1, bus.sel0};

   assign sum  = bus.in1 + bus.in2;
   assign diff = bus.in1 - bus.in2;

   // Signed less-than is N xor V of in1-in2; equality is the zero flag.
   assign fl.z = (diff == '0);
   assign fl.n = diff[WIDTH-1];
   assign fl.v = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) && (diff[WIDTH-1] != bus.in1[WIDTH-1]);
   assign lt   = fl.n ^ fl.v;

   always_comb begin
      sh_mode = SH_SRL;
      if (op == OP_SLL)      sh_mode = SH_SLL;
      else if (op == OP_SRA) sh_mode = SH_SRA;
   end

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .data  (bus.in1),
      .shamt (bus.in2[4:0]),
      .mode  (sh_mode),
      .res   (sh_res)
   );

   always_comb begin
      res = '0;
      case (op)
         OP_AND: res = bus.in1 & bus.in2;
         OP_OR:  res = bus.in1 | bus.in2;
         OP_XOR: res = bus.in1 ^ bus.in2;
         OP_SLL, OP_SRA, OP_SRL: res = sh_res;
         OP_ADD: res = sum;
         OP_SUB: res = diff;
         OP_SEQ: res = {{(WIDTH-1){1'b0}}, fl.z};
         OP_SNE: res = {{(WIDTH-1){1'b0}}, ~fl.z};
         OP_SLT: res = {{(WIDTH-1){1'b0}}, lt};
         OP_SGT: res = {{(WIDTH-1){1'b0}}, ~lt & ~fl.z};
         OP_SLE: res = {{(WIDTH-1){1'b0}}, lt | fl.z};
         OP_SGE: res = {{(WIDTH-1){1'b0}}, ~lt};
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_q <= '0;
      else     out_q <= res;
   end

   assign bus.out = out_q;

endmodule

// File: tb/tb_alu.sv
// Randomized + directed scoreboard bench for the ALU.
module tb_alu;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] exp;
      string       nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   alu_if #(.WIDTH(32)) bus ();

   alu #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, logic [5:0] op);
      int unsigned sh;
      logic signed [31:0] sa, sb_;
      sh  = b % 32;
      sa  = a;
      sb_ = b;
      case (op)
         OP_AND: return a & b;
         OP_OR:  return a | b;
         OP_XOR: return a ^ b;
         OP_SLL: return a << sh;
         OP_SRL: return a >> sh;
         OP_SRA: return 32'(sa >>> sh);
         OP_ADD: return 32'(a + b);
         OP_SUB: return 32'(a - b);
         OP_SEQ: return (sa == sb_) ? 32'd1 : 32'd0;
         OP_SNE: return (sa != sb_) ? 32'd1 : 32'd0;
         OP_SLT: return (sa <  sb_) ? 32'd1 : 32'd0;
         OP_SGT: return (sa >  sb_) ? 32'd1 : 32'd0;
         OP_SLE: return (sa <= sb_) ? 32'd1 : 32'd0;
         OP_SGE: return (sa >= sb_) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
      bus.in1 = a;
      bus.in2 = b;
      {bus.sel5, bus.sel4, bus.sel3, bus.sel2, bus.sel1, bus.sel0} = op;
   endtask

   // Directed: required value comes straight from the expected-results table.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op,
                        input logic [31:0] req, input string nm);
      exp_t e;
      @(negedge clk);
      drive(a, b, op);
      e.exp = req;
      e.nm  = nm;
      sb.push_back(e);
   endtask

   task automatic issue_rand(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
      issue(a, b, op, model(a, b, op), $sformatf("rand op=%06b", op));
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_now(input string nm, input logic [31:0] req);
      checks++;
      if (bus.out !== req) begin
         failures++;
         $display("FAIL %s: out=%08h required=%08h", nm, bus.out, req);
      end
   endtask

   // Monitor: one result per edge, compared against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0 && !rst) begin
            e = sb.pop_front();
            checks++;
            if (bus.out !== e.exp) begin
               failures++;
               $display("FAIL %s: out=%08h required=%08h", e.nm, bus.out, e.exp);
            end
         end
      end
   end

   initial begin
      logic [5:0] ops [14];
      logic [31:0] a, b;
      logic [5:0]  op;
      ops = '{OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRA, OP_SRL, OP_ADD,
              OP_SUB, OP_SEQ, OP_SNE, OP_SLT, OP_SGT, OP_SLE, OP_SGE};

      drive(32'hDEADBEEF, 32'h12345678, OP_ADD);
      #1;
      check_now("reset_state", 32'h0);
      @(posedge clk);
      #1;
      check_now("reset_hold", 32'h0);
      @(negedge clk);
      rst = 1'b0;

      issue(32'hF0F0F0F0, 32'hFF00FF00, OP_AND, 32'hF000F000, "and");
      issue(32'hF0F0F0F0, 32'hFF00FF00, OP_OR,  32'hFFF0FFF0, "or");
      issue(32'hF0F0F0F0, 32'hFF00FF00, OP_XOR, 32'h0FF00FF0, "xor");
      issue(32'h00000001, 32'd31,       OP_SLL, 32'h80000000, "sll31");
      issue(32'h80000000, 32'd4,        OP_SRA, 32'hF8000000, "sra4");
      issue(32'h80000000, 32'd4,        OP_SRL, 32'h08000000, "srl4");
      issue(32'h00000001, 32'hFFFFFFE3, OP_SLL, 32'h00000008, "sll_hi_ignored");
      issue(32'h80000000, 32'hFFFFFFE3, OP_SRL, 32'h10000000, "srl_hi_ignored");
      issue(32'h12345678, 32'h00000000, OP_SRA, 32'h12345678, "shift0");
      issue(32'hFFFFFFFF, 32'h00000001, OP_ADD, 32'h00000000, "add_wrap");
      issue(32'h00000000, 32'h00000001, OP_SUB, 32'hFFFFFFFF, "sub_wrap");
      issue(32'hFFFFFFFF, 32'h00000001, OP_SLT, 32'h1, "slt_neg");
      issue(32'hFFFFFFFF, 32'h00000001, OP_SGT, 32'h0, "sgt_neg");
      issue(32'hFFFFFFFF, 32'h00000001, OP_SLE, 32'h1, "sle_neg");
      issue(32'hFFFFFFFF, 32'h00000001, OP_SGE, 32'h0, "sge_neg");
      issue(32'hFFFFFFFF, 32'h00000001, OP_SNE, 32'h1, "sne_neg");
      issue(32'h0000ABCD, 32'h0000ABCD, OP_SEQ, 32'h1, "seq_eq");
      issue(32'h0000ABCD, 32'h0000ABCD, OP_SLE, 32'h1, "sle_eq");
      issue(32'h0000ABCD, 32'h0000ABCD, OP_SGE, 32'h1, "sge_eq");
      issue(32'h0000ABCD, 32'h0000ABCD, OP_SNE, 32'h0, "sne_eq");
      issue(32'h80000000, 32'h7FFFFFFF, OP_SLT, 32'h1, "slt_ovf");
      issue(32'h80000000, 32'h7FFFFFFF, OP_SGT, 32'h0, "sgt_ovf");
      issue(32'h7FFFFFFF, 32'h80000000, OP_SGT, 32'h1, "sgt_ovf_rev");
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 6'b111111, 32'h0, "illegal_3f");
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 6'b000011, 32'h0, "illegal_03");
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 6'b000111, 32'h0, "illegal_07");

      for (int i = 0; i < 400; i++) begin
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         else                          op = ops[$urandom_range(0, 13)];
         issue_rand(a, b, op);
      end

      // Async reset between edges with a nonzero result on out.
      issue(32'hF0F0F0F0, 32'hFF00FF00, OP_OR, 32'hFFF0FFF0, "pre_reset");
      drain();
      rst = 1'b1;
      #1;
      check_now("async_reset", 32'h0);
      @(negedge clk);
      drive(32'h11111111, 32'h22222222, OP_ADD);
      @(posedge clk);
      #1;
      check_now("reset_hold_inputs", 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(32'h11111111, 32'h22222222, OP_ADD);
      sb.push_back('{exp: 32'h33333333, nm: "post_reset_first"});
      issue(32'h00000005, 32'h00000003, OP_SUB, 32'h00000002, "post_reset_second");
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: time=%0t required=finish", $time);
      $fatal(1, "timeout");
   end

endmodule
